// File: rtl/wb_multi_commit.sv
// wb_multi_commit: multi-lane writeback/commit stage.
//   Resolves per-lane kills (exception, redirect, non-cacop refetch), squashes
//   younger lanes behind the oldest killing lane, registers the writeback
//   record, forwards results combinationally to dispatch, and tracks pending
//   store commits with a credit counter that stalls the stage when a full
//   bundle of stores could no longer fit.
// Ports:
//   clk, rst (sync, active high), flush, advance
//   mem_*            per-lane inputs from the memory stage (lane 0 oldest)
//   wb_*             registered writeback outputs
//   fwd_*            combinational forwarding to dispatch
//   dcache_flush_o   any lane killing this cycle
//   st_commit_*      store-commit handshake, one store per ready cycle
//   stall_o          stage cannot accept another bundle
//   diff_*           difftest commit record
// Optional build macro: DIFFTEST_COMMIT_EN registers the diff_* record;
// without it the diff_* outputs are tied to zero.
module wb_multi_commit #(
    parameter int COMMIT_WIDTH  = 2,
    parameter int STORE_Q_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         advance,
    input  logic [COMMIT_WIDTH-1:0]      mem_valid,
    input  logic [COMMIT_WIDTH-1:0]      mem_excp,
    input  logic [COMMIT_WIDTH-1:0]      mem_redirect,
    input  logic [COMMIT_WIDTH-1:0]      mem_refetch,
    input  logic [COMMIT_WIDTH-1:0]      mem_cacop,
    input  logic [COMMIT_WIDTH-1:0]      mem_store,
    input  logic [COMMIT_WIDTH-1:0]      mem_wreg,
    input  logic [5*COMMIT_WIDTH-1:0]    mem_waddr,
    input  logic [32*COMMIT_WIDTH-1:0]   mem_wdata,
    input  logic [32*COMMIT_WIDTH-1:0]   mem_pc,
    input  logic [32*COMMIT_WIDTH-1:0]   mem_instr,
    output logic [COMMIT_WIDTH-1:0]      wb_valid,
    output logic [COMMIT_WIDTH-1:0]      wb_we,
    output logic [5*COMMIT_WIDTH-1:0]    wb_waddr,
    output logic [32*COMMIT_WIDTH-1:0]   wb_wdata,
    output logic [32*COMMIT_WIDTH-1:0]   wb_pc,
    output logic [COMMIT_WIDTH-1:0]      fwd_valid,
    output logic [5*COMMIT_WIDTH-1:0]    fwd_waddr,
    output logic [32*COMMIT_WIDTH-1:0]   fwd_wdata,
    output logic                         dcache_flush_o,
    output logic                         st_commit_valid_o,
    input  logic                         st_commit_ready_i,
    output logic                         stall_o,
    output logic [32*COMMIT_WIDTH-1:0]   diff_pc,
    output logic [32*COMMIT_WIDTH-1:0]   diff_instr,
    output logic [COMMIT_WIDTH-1:0]      diff_st_en
);

    localparam int CW = $clog2(STORE_Q_DEPTH + 1);

    logic [COMMIT_WIDTH-1:0]    eff_valid;
    logic [COMMIT_WIDTH-1:0]    kill;
    logic [COMMIT_WIDTH-1:0]    st_lane;
    logic [COMMIT_WIDTH-1:0]    we_lane;
    logic                       blocked;
    logic [CW-1:0]              push_cnt;
    logic [CW-1:0]              cnt;
    logic                       pop;
    logic                       accept;
    logic [5*COMMIT_WIDTH-1:0]  waddr_m;
    logic [32*COMMIT_WIDTH-1:0] wdata_m;
    logic [32*COMMIT_WIDTH-1:0] pc_m;

    // Walk lanes oldest first: once a lane kills, every younger lane is squashed.
    always_comb begin
        blocked   = 1'b0;
        eff_valid = '0;
        kill      = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            eff_valid[i] = mem_valid[i] & ~blocked;
            kill[i]      = eff_valid[i] &
                           (mem_excp[i] | mem_redirect[i] | (mem_refetch[i] & ~mem_cacop[i]));
            blocked      = blocked | kill[i];
        end
    end

    assign st_lane = eff_valid & mem_store & ~mem_excp;
    assign we_lane = eff_valid & mem_wreg & ~mem_excp;

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            push_cnt = push_cnt + CW'(st_lane[i]);
        end
    end

    always_comb begin
        waddr_m = '0;
        wdata_m = '0;
        pc_m    = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (eff_valid[i]) begin
                waddr_m[5*i +: 5]   = mem_waddr[5*i +: 5];
                wdata_m[32*i +: 32] = mem_wdata[32*i +: 32];
                pc_m[32*i +: 32]    = mem_pc[32*i +: 32];
            end
        end
    end

    assign dcache_flush_o    = |kill;
    assign fwd_valid         = we_lane;
    assign fwd_waddr         = mem_waddr;
    assign fwd_wdata         = mem_wdata;

    // Stall whenever a full bundle of stores might overflow the credit pool,
    // which keeps cnt + push_cnt <= STORE_Q_DEPTH on every accept.
    assign stall_o           = (32'(cnt) + 32'(COMMIT_WIDTH)) > 32'(STORE_Q_DEPTH);
    assign accept            = advance & ~stall_o & ~flush & ~rst;
    assign pop               = (cnt != '0) & st_commit_ready_i;
    assign st_commit_valid_o = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= '0;
            wb_we    <= '0;
            wb_waddr <= '0;
            wb_wdata <= '0;
            wb_pc    <= '0;
            cnt      <= '0;
        end else begin
            // Committed stores keep draining through flush.
            cnt <= cnt + (accept ? push_cnt : CW'(0)) - CW'(pop);
            if (flush) begin
                wb_valid <= '0;
                wb_we    <= '0;
            end else if (accept) begin
                wb_valid <= eff_valid;
                wb_we    <= we_lane;
                wb_waddr <= waddr_m;
                wb_wdata <= wdata_m;
                wb_pc    <= pc_m;
            end
        end
    end

`ifdef DIFFTEST_COMMIT_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            diff_pc    <= '0;
            diff_instr <= '0;
            diff_st_en <= '0;
        end else if (accept) begin
            diff_pc    <= mem_pc;
            diff_instr <= mem_instr;
            diff_st_en <= st_lane;
        end
    end
`else
    assign diff_pc    = '0;
    assign diff_instr = '0;
    assign diff_st_en = '0;

    logic unused_diff;
    assign unused_diff = ^mem_instr;
`endif

endmodule

// File: tb/tb_wb_multi_commit.sv
module tb_wb_multi_commit;
    localparam int W = 2;

    logic          clk = 1'b0;
    logic          rst, flush, advance;
    logic [W-1:0]  mem_valid, mem_excp, mem_redirect, mem_refetch, mem_cacop, mem_store, mem_wreg;
    logic [5*W-1:0]  mem_waddr;
    logic [32*W-1:0] mem_wdata, mem_pc, mem_instr;
    logic [W-1:0]    wb_valid, wb_we, fwd_valid, diff_st_en;
    logic [5*W-1:0]  wb_waddr, fwd_waddr;
    logic [32*W-1:0] wb_wdata, wb_pc, fwd_wdata, diff_pc, diff_instr;
    logic            dcache_flush_o, st_commit_valid_o, st_commit_ready_i, stall_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_multi_commit #(.COMMIT_WIDTH(W), .STORE_Q_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .advance(advance),
        .mem_valid(mem_valid), .mem_excp(mem_excp), .mem_redirect(mem_redirect),
        .mem_refetch(mem_refetch), .mem_cacop(mem_cacop), .mem_store(mem_store),
        .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_pc(mem_pc), .mem_instr(mem_instr),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_pc(wb_pc), .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .dcache_flush_o(dcache_flush_o), .st_commit_valid_o(st_commit_valid_o),
        .st_commit_ready_i(st_commit_ready_i), .stall_o(stall_o),
        .diff_pc(diff_pc), .diff_instr(diff_instr), .diff_st_en(diff_st_en)
    );

    typedef struct {
        logic [1:0] valid, excp, redir, refetch, cacop, store, wreg;
        logic       e_flush;
        logic [1:0] e_fwd, e_wbv, e_we;
        int         e_push;
    } vec_t;

    vec_t vecs[9];
    vec_t zero_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        mem_valid    = v.valid;
        mem_excp     = v.excp;
        mem_redirect = v.redir;
        mem_refetch  = v.refetch;
        mem_cacop    = v.cacop;
        mem_store    = v.store;
        mem_wreg     = v.wreg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0]  exp_waddr;
    logic [63:0] exp_wdata;

    initial begin
        //           valid  excp   redir  refet  cacop  store  wreg   fl    fwd    wbv    we     push
        vecs[0] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 2'b10, 2'b11, 2'b10, 1};
        vecs[1] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b00, 2'b01, 2'b00, 0};
        vecs[2] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 1'b0, 2'b11, 2'b11, 2'b11, 0};
        vecs[3] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 1'b1, 2'b01, 2'b01, 2'b01, 0};
        vecs[4] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 2'b11, 2'b11, 2'b11, 2};
        vecs[5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 2'b00, 2'b10, 2'b00, 0};
        vecs[6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 0};
        vecs[8] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 0};
        zero_v  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 0};

        rst = 1'b1; flush = 1'b0; advance = 1'b0; st_commit_ready_i = 1'b0;
        apply(zero_v);
        mem_waddr = {5'd5, 5'd3};
        mem_wdata = {32'h0000_1234, 32'h0000_a5a5};
        mem_pc    = {32'h0000_1004, 32'h0000_1000};
        mem_instr = {32'h0280_0c05, 32'h2980_0001};
        step(); step();
        chk("reset_wb_valid", 64'(wb_valid), 64'h0);
        chk("reset_st_valid", 64'(st_commit_valid_o), 64'h0);
        chk("reset_stall", 64'(stall_o), 64'h0);
        chk("reset_wb_pc", wb_pc, 64'h0);
        rst = 1'b0;

        // Table: each vector accepted from an empty store queue, then drained.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            advance = 1'b1;
            st_commit_ready_i = 1'b1;
            #1;
            chk($sformatf("v%0d_dcache_flush", i), 64'(dcache_flush_o), 64'(vecs[i].e_flush));
            chk($sformatf("v%0d_fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].e_fwd));
            step();
            advance = 1'b0;
            apply(zero_v);
            exp_waddr = {vecs[i].e_wbv[1] ? 5'd5 : 5'd0, vecs[i].e_wbv[0] ? 5'd3 : 5'd0};
            exp_wdata = {vecs[i].e_wbv[1] ? 32'h1234 : 32'h0, vecs[i].e_wbv[0] ? 32'ha5a5 : 32'h0};
            chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(vecs[i].e_wbv));
            chk($sformatf("v%0d_wb_we", i), 64'(wb_we), 64'(vecs[i].e_we));
            chk($sformatf("v%0d_wb_waddr", i), 64'(wb_waddr), 64'(exp_waddr));
            chk($sformatf("v%0d_wb_wdata", i), wb_wdata, exp_wdata);
            chk($sformatf("v%0d_cnt", i), 64'(dut.cnt), 64'(vecs[i].e_push));
            chk($sformatf("v%0d_st_valid", i), 64'(st_commit_valid_o), 64'(vecs[i].e_push != 0));
            for (int k = 0; k < 4; k++) begin
                if (st_commit_valid_o == 1'b0) break;
                step();
            end
            chk($sformatf("v%0d_drained", i), 64'(st_commit_valid_o), 64'h0);
            chk($sformatf("v%0d_wb_hold", i), 64'(wb_valid), 64'(vecs[i].e_wbv));
        end

        // Fill to cnt=3 with ready low; stall must block the next advance.
        st_commit_ready_i = 1'b0;
        apply(vecs[6]); advance = 1'b1; step();
        apply(vecs[0]); step();
        advance = 1'b0; apply(zero_v);
        chk("fill_cnt3", 64'(dut.cnt), 64'd3);
        chk("fill_stall", 64'(stall_o), 64'h1);
        chk("fill_st_valid", 64'(st_commit_valid_o), 64'h1);
        apply(vecs[4]); advance = 1'b1; step();
        advance = 1'b0; apply(zero_v);
        chk("stalled_cnt", 64'(dut.cnt), 64'd3);
        chk("stalled_wb_we_hold", 64'(wb_we), 64'h2);
        chk("stalled_wb_valid_hold", 64'(wb_valid), 64'h3);
        st_commit_ready_i = 1'b1; step();
        st_commit_ready_i = 1'b0;
        chk("pop_cnt2", 64'(dut.cnt), 64'd2);
        chk("pop_stall_clear", 64'(stall_o), 64'h0);

        // cnt=2: push two and pop one in the same cycle, then flush.
        apply(vecs[6]); advance = 1'b1; st_commit_ready_i = 1'b1; step();
        advance = 1'b0; st_commit_ready_i = 1'b0; apply(zero_v);
        chk("pushpop_cnt3", 64'(dut.cnt), 64'd3);
        chk("pushpop_wb_valid", 64'(wb_valid), 64'h3);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("flush_cnt_kept", 64'(dut.cnt), 64'd3);
        chk("flush_wb_valid", 64'(wb_valid), 64'h0);
        chk("flush_wb_we", 64'(wb_we), 64'h0);
        chk("flush_data_hold", wb_wdata, {32'h1234, 32'ha5a5});
        chk("flush_st_valid", 64'(st_commit_valid_o), 64'h1);

        // Reset with stores pending discards them.
        rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_cnt", 64'(dut.cnt), 64'd0);
        chk("rst_st_valid", 64'(st_commit_valid_o), 64'h0);
        chk("rst_wb_valid", 64'(wb_valid), 64'h0);
        chk("rst_wb_waddr", 64'(wb_waddr), 64'h0);
        chk("rst_wb_wdata", wb_wdata, 64'h0);
        chk("rst_diff_pc", diff_pc, 64'h0);
        chk("rst_diff_st_en", 64'(diff_st_en), 64'h0);

        // Flush beats a simultaneous advance: nothing captured, nothing pushed.
        apply(vecs[2]); advance = 1'b1; step();
        chk("pre_flush_wb_valid", 64'(wb_valid), 64'h3);
        apply(vecs[6]); flush = 1'b1; step();
        flush = 1'b0; advance = 1'b0; apply(zero_v);
        chk("flushadv_wb_valid", 64'(wb_valid), 64'h0);
        chk("flushadv_cnt", 64'(dut.cnt), 64'd0);
        chk("flushadv_st_valid", 64'(st_commit_valid_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_multi_commit.md
WB_MULTI_COMMIT -- requirements
Module: wb_multi_commit

Interface
REQ-001 Parameter COMMIT_WIDTH, default 2: number of writeback lanes; lane 0 is oldest.
REQ-002 Parameter STORE_Q_DEPTH, default 4: pending store-commit credit capacity; SHALL be >= COMMIT_WIDTH.
REQ-003 clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-004 flush  in  1  pipeline flush; advance  in  1  accept current lane inputs.
REQ-005 mem_valid/mem_excp/mem_redirect/mem_refetch/mem_cacop/mem_store/mem_wreg  in  COMMIT_WIDTH  per-lane flags.
REQ-006 mem_waddr  in  5*COMMIT_WIDTH; mem_wdata, mem_pc, mem_instr  in  32*COMMIT_WIDTH.
REQ-007 wb_valid, wb_we  out  COMMIT_WIDTH; wb_waddr  out  5*COMMIT_WIDTH; wb_wdata, wb_pc  out  32*COMMIT_WIDTH: registered commit outputs.
REQ-008 fwd_valid  out  COMMIT_WIDTH; fwd_waddr  out  5*COMMIT_WIDTH; fwd_wdata  out  32*COMMIT_WIDTH: combinational forwarding to dispatch.
REQ-009 dcache_flush_o  out  1; st_commit_valid_o  out  1; st_commit_ready_i  in  1; stall_o  out  1.
REQ-010 diff_pc, diff_instr  out  32*COMMIT_WIDTH; diff_st_en  out  COMMIT_WIDTH: difftest commit record.

Function
REQ-011 Lane i is "killing" when eff_valid[i] & (excp | redirect | (refetch & ~cacop)).
REQ-012 eff_valid[i] = mem_valid[i] & no lane j<i killing; younger lanes behind a killing lane are squashed.
REQ-013 A killing lane with excp keeps eff_valid but SHALL have wb_we=0 and no store commit.
REQ-014 dcache_flush_o SHALL be combinational OR of killing over all lanes.
REQ-015 fwd_valid[i] = eff_valid[i] & mem_wreg[i] & ~mem_excp[i], combinational, zero latency.
REQ-016 Accept = advance & ~stall_o & ~flush & ~rst.
REQ-017 On accept, all wb_* registers capture eff_valid-masked lane inputs; latency 1 cycle.
REQ-018 On flush (not rst), wb_valid and wb_we SHALL clear next cycle; data fields may hold.
REQ-019 Neither accept nor flush: all wb_* outputs hold.
REQ-020 advance while stall_o=1 SHALL be ignored (outputs hold, no store push).
REQ-021 Push count P = number of lanes with eff_valid & mem_store & ~mem_excp, counted only on accept.
REQ-022 Pending counter cnt, width clog2(STORE_Q_DEPTH+1); pop = (cnt!=0) & st_commit_ready_i.
REQ-023 cnt_next = cnt + P - pop in the same cycle; simultaneous push and pop SHALL both take effect.
REQ-024 st_commit_valid_o = (cnt != 0); one store commit per ready handshake.
REQ-025 stall_o = (cnt + COMMIT_WIDTH > STORE_Q_DEPTH), combinational from registered cnt; cnt never exceeds STORE_Q_DEPTH.
REQ-026 flush SHALL NOT clear cnt: already-committed stores still drain.

Reset
REQ-027 On rst: wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, cnt, diff_* SHALL be 0.
REQ-028 rst mid-drain discards pending stores; st_commit_valid_o=0 the cycle after rst.
REQ-029 rst has priority over flush, which has priority over advance.

Configuration
REQ-030 Macro DIFFTEST_COMMIT_EN: when defined, diff_pc/diff_instr/diff_st_en register mem_pc/mem_instr/(eff_valid&store&~excp) on accept, clear on flush/rst.
REQ-031 Without DIFFTEST_COMMIT_EN, diff_* outputs SHALL be constant 0 and no registers inferred for them.

Verification
REQ-032 W=2: lane0 store ~excp, lane1 wreg r5=0x1234, advance, ready=0 -> next cycle wb_valid=2'b11, wb_we[1]=1, cnt=1, st_commit_valid_o=1.
REQ-033 Lane0 excp=1, lane1 valid -> dcache_flush_o=1 same cycle, next cycle wb_valid=2'b01, wb_we=0, cnt unchanged.
REQ-034 Lane0 refetch&cacop=1 -> not killing, dcache_flush_o=0, lane1 commits.
REQ-035 DEPTH=4, cnt=3, ready=0 -> stall_o=1, advance ignored; ready=1 one cycle -> cnt=2, stall_o=0.
REQ-036 cnt=2, accept with 2 stores and ready=1 same cycle -> cnt=3; flush next cycle -> cnt still 3, wb_valid=0.
REQ-037 rst asserted with cnt=3 -> next cycle cnt=0, all outputs 0.
